// File: rtl/vga_fml_arb.sv
// Two-master FML arbiter: merges LCD refresh and CPU traffic onto one SDRAM port.
// LCD has priority, with a bounded run of back-to-back LCD grants while the CPU waits.
module vga_fml_arb #(
  parameter int unsigned fml_depth = 20,
  parameter int unsigned burst_len = 4,
  parameter int unsigned lcd_max   = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] lcd_fml_adr,
  input  logic                 lcd_fml_stb,
  input  logic                 lcd_fml_we,
  input  logic [1:0]           lcd_fml_sel,
  input  logic [15:0]          lcd_fml_do,
  output logic                 lcd_fml_ack,
  output logic [15:0]          lcd_fml_di,

  input  logic [fml_depth-1:0] cpu_fml_adr,
  input  logic                 cpu_fml_stb,
  input  logic                 cpu_fml_we,
  input  logic [1:0]           cpu_fml_sel,
  input  logic [15:0]          cpu_fml_do,
  output logic                 cpu_fml_ack,
  output logic [15:0]          cpu_fml_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGntLcd = 2'd1;
  localparam logic [1:0] StGntCpu = 2'd2;
  localparam logic [1:0] StBurst  = 2'd3;

  localparam int unsigned     CntW    = (burst_len > 2) ? $clog2(burst_len) : 1;
  localparam logic [CntW-1:0] CntLoad = (burst_len > 1) ? CntW'(burst_len - 2) : '0;
  localparam logic [2:0]      LcdMax  = 3'(lcd_max);

  logic [1:0]      state_q, state_d;
  logic [2:0]      lcd_run_q, lcd_run_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic            owner_q, owner_d;  // 0 = LCD, 1 = CPU
  logic            gnt_stb;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q   <= StIdle;
      lcd_run_q <= '0;
      beat_q    <= '0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcd_run_q <= lcd_run_d;
      beat_q    <= beat_d;
      owner_q   <= owner_d;
    end
  end

  assign gnt_stb = (state_q == StGntCpu) ? cpu_fml_stb : lcd_fml_stb;

  always_comb begin
    state_d   = state_q;
    lcd_run_d = lcd_run_q;
    beat_d    = beat_q;
    owner_d   = owner_q;
    case (state_q)
      StIdle: begin
        if (lcd_fml_stb && (!cpu_fml_stb || lcd_run_q != LcdMax)) begin
          state_d = StGntLcd;
          owner_d = 1'b0;
          // Only reachable below LcdMax when the CPU waits, so this saturates at LcdMax.
          lcd_run_d = cpu_fml_stb ? lcd_run_q + 3'd1 : 3'd0;
        end else if (cpu_fml_stb) begin
          state_d   = StGntCpu;
          owner_d   = 1'b1;
          lcd_run_d = '0;
        end else begin
          lcd_run_d = '0;
        end
      end
      StGntLcd, StGntCpu: begin
        if (!gnt_stb) begin
          state_d = StIdle;
        end else if (fml_ack) begin
          if (burst_len == 1) begin
            state_d = StIdle;
          end else begin
            state_d = StBurst;
            beat_d  = CntLoad;
          end
        end
      end
      StBurst: begin
        if (beat_q == '0) begin
          state_d = StIdle;
        end else begin
          beat_d = beat_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fml_adr     = owner_q ? cpu_fml_adr : lcd_fml_adr;
    fml_we      = owner_q ? cpu_fml_we  : lcd_fml_we;
    fml_sel     = owner_q ? cpu_fml_sel : lcd_fml_sel;
    fml_do      = '0;
    fml_stb     = 1'b0;
    lcd_fml_ack = 1'b0;
    cpu_fml_ack = 1'b0;
    if (state_q != StIdle) begin
      fml_do = owner_q ? cpu_fml_do : lcd_fml_do;
    end
    if (state_q == StGntLcd) begin
      fml_stb     = lcd_fml_stb;
      lcd_fml_ack = fml_ack;
    end
    if (state_q == StGntCpu) begin
      fml_stb     = cpu_fml_stb;
      cpu_fml_ack = fml_ack;
    end
  end

  // Read data is shared; each master qualifies it with its own ack and beat timing.
  assign lcd_fml_di = fml_di;
  assign cpu_fml_di = fml_di;

endmodule

// File: tb/tb_vga_fml_arb.sv
// Self-checking bench for vga_fml_arb: a small SDRAM ack model plus an ack-order scoreboard.
module tb_vga_fml_arb;

  localparam int unsigned FmlDepth = 20;
  localparam logic [FmlDepth-1:0] LcdAdr = 20'h00100;
  localparam logic [FmlDepth-1:0] CpuAdr = 20'h0ABCD;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b0;
  logic [FmlDepth-1:0] lcd_fml_adr = '0, cpu_fml_adr = '0, fml_adr;
  logic                lcd_fml_stb = 1'b0, cpu_fml_stb = 1'b0, fml_stb;
  logic                lcd_fml_we = 1'b0, cpu_fml_we = 1'b0, fml_we;
  logic [1:0]          lcd_fml_sel = 2'b11, cpu_fml_sel = 2'b11, fml_sel;
  logic [15:0]         lcd_fml_do = '0, cpu_fml_do = '0, fml_do;
  logic                lcd_fml_ack, cpu_fml_ack, fml_ack;
  logic [15:0]         lcd_fml_di, cpu_fml_di;
  logic [15:0]         fml_di = '0;

  int checks = 0;
  int errors = 0;
  int ack_lat = 1;
  logic [7:0] stb_cnt = '0;

  typedef struct packed {
    logic                cpu;
    logic [FmlDepth-1:0] adr;
  } exp_t;
  exp_t sb[$];

  always #5 sys_clk = ~sys_clk;

  vga_fml_arb #(
    .fml_depth(FmlDepth),
    .burst_len(4),
    .lcd_max  (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .lcd_fml_adr(lcd_fml_adr),
    .lcd_fml_stb(lcd_fml_stb),
    .lcd_fml_we (lcd_fml_we),
    .lcd_fml_sel(lcd_fml_sel),
    .lcd_fml_do (lcd_fml_do),
    .lcd_fml_ack(lcd_fml_ack),
    .lcd_fml_di (lcd_fml_di),
    .cpu_fml_adr(cpu_fml_adr),
    .cpu_fml_stb(cpu_fml_stb),
    .cpu_fml_we (cpu_fml_we),
    .cpu_fml_sel(cpu_fml_sel),
    .cpu_fml_do (cpu_fml_do),
    .cpu_fml_ack(cpu_fml_ack),
    .cpu_fml_di (cpu_fml_di),
    .fml_adr    (fml_adr),
    .fml_stb    (fml_stb),
    .fml_we     (fml_we),
    .fml_sel    (fml_sel),
    .fml_do     (fml_do),
    .fml_ack    (fml_ack),
    .fml_di     (fml_di)
  );

  // SDRAM model: acks on the ack_lat-th consecutive cycle of fml_stb.
  always @(posedge sys_clk) stb_cnt <= (fml_stb && !fml_ack) ? stb_cnt + 8'd1 : 8'd0;
  assign fml_ack = fml_stb && (stb_cnt == 8'(ack_lat - 1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin : mon
    exp_t e;
    if (sys_rst && (lcd_fml_ack || cpu_fml_ack)) begin
      check("one_ack", 32'(lcd_fml_ack & cpu_fml_ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({cpu_fml_ack, lcd_fml_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_owner", 32'(cpu_fml_ack), 32'(e.cpu));
        check("ack_adr", 32'(fml_adr), 32'(e.adr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with both masters requesting: nothing may reach the FML side.
    lcd_fml_stb = 1'b1;
    cpu_fml_stb = 1'b1;
    lcd_fml_do  = 16'h1234;
    cpu_fml_do  = 16'h5678;
    repeat (3) tick();
    check("rst_fml_stb", 32'(fml_stb), 32'd0);
    check("rst_lcd_ack", 32'(lcd_fml_ack), 32'd0);
    check("rst_cpu_ack", 32'(cpu_fml_ack), 32'd0);
    check("rst_fml_do", 32'(fml_do), 32'd0);
    check("rst_lcd_run", 32'(dut.lcd_run_q), 32'd0);
    lcd_fml_stb = 1'b0;
    cpu_fml_stb = 1'b0;
    tick();
    sys_rst = 1'b1;
    repeat (2) tick();

    // LCD-only read, ack on the third stb cycle.
    ack_lat = 3;
    fml_di  = 16'hC3C3;
    tick();
    lcd_fml_adr = LcdAdr;
    lcd_fml_stb = 1'b1;
    sb.push_back('{cpu: 1'b0, adr: LcdAdr});
    #1;
    check("t1_c0_stb", 32'(fml_stb), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t1_gnt_stb", 32'(fml_stb), 32'd1);
      check("t1_gnt_adr", 32'(fml_adr), 32'(LcdAdr));
      check("t1_lcd_ack", 32'(lcd_fml_ack), 32'(c == 3));
      check("t1_cpu_ack", 32'(cpu_fml_ack), 32'd0);
    end
    check("t1_lcd_di", 32'(lcd_fml_di), 32'h0000C3C3);
    check("t1_cpu_di", 32'(cpu_fml_di), 32'h0000C3C3);
    for (int c = 4; c <= 6; c++) begin
      tick();
      if (c == 4) lcd_fml_stb = 1'b0;
      #1;
      check("t1_burst_stb", 32'(fml_stb), 32'd0);
      check("t1_burst_do", 32'(fml_do), 32'h00001234);
    end
    tick();
    check("t1_idle_do", 32'(fml_do), 32'd0);
    check("t1_idle_stb", 32'(fml_stb), 32'd0);
    tick();

    // CPU write: we/sel/do must follow the CPU for all four beats.
    ack_lat    = 2;
    lcd_fml_do = 16'h1111;
    tick();
    cpu_fml_adr = CpuAdr;
    cpu_fml_we  = 1'b1;
    cpu_fml_sel = 2'b01;
    cpu_fml_do  = 16'hA55A;
    cpu_fml_stb = 1'b1;
    sb.push_back('{cpu: 1'b1, adr: CpuAdr});
    #1;
    tick();
    check("t3_gnt_stb", 32'(fml_stb), 32'd1);
    check("t3_early_ack", 32'(cpu_fml_ack), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 3) cpu_fml_stb = 1'b0;
      #1;
      check("t3_we", 32'(fml_we), 32'd1);
      check("t3_sel", 32'(fml_sel), 32'd1);
      check("t3_do", 32'(fml_do), 32'h0000A55A);
      check("t3_lcd_ack", 32'(lcd_fml_ack), 32'd0);
      check("t3_cpu_ack", 32'(cpu_fml_ack), 32'(c == 2));
    end
    tick();
    check("t3_idle_do", 32'(fml_do), 32'd0);
    cpu_fml_we = 1'b0;
    tick();

    // Both masters continuously requesting from reset release.
    sys_rst     = 1'b0;
    ack_lat     = 1;
    lcd_fml_stb = 1'b1;
    cpu_fml_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) sb.push_back('{cpu: 1'b1, adr: CpuAdr});
      else sb.push_back('{cpu: 1'b0, adr: LcdAdr});
    end
    repeat (2) tick();
    sys_rst = 1'b1;
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check("t2_drain", 32'(sb.size()), 32'd0);
    lcd_fml_stb = 1'b0;
    cpu_fml_stb = 1'b0;
    repeat (6) tick();

    // Reset on the second beat aborts the burst; CPU is then granted in one cycle.
    lcd_fml_do = 16'h7777;
    tick();
    lcd_fml_stb = 1'b1;
    cpu_fml_stb = 1'b1;
    sb.push_back('{cpu: 1'b0, adr: LcdAdr});
    #1;
    tick();
    check("t4_lcd_ack", 32'(lcd_fml_ack), 32'd1);
    tick();
    lcd_fml_stb = 1'b0;
    #1;
    check("t4_burst_do", 32'(fml_do), 32'h00007777);
    check("t4_run_before", 32'(dut.lcd_run_q), 32'd1);
    sys_rst = 1'b0;
    tick();
    check("t4_rst_stb", 32'(fml_stb), 32'd0);
    check("t4_rst_do", 32'(fml_do), 32'd0);
    check("t4_rst_run", 32'(dut.lcd_run_q), 32'd0);
    sb.push_back('{cpu: 1'b1, adr: CpuAdr});
    sys_rst = 1'b1;
    tick();
    check("t4_cpu_stb", 32'(fml_stb), 32'd1);
    check("t4_cpu_adr", 32'(fml_adr), 32'(CpuAdr));
    check("t4_cpu_ack", 32'(cpu_fml_ack), 32'd1);
    tick();
    cpu_fml_stb = 1'b0;
    repeat (4) tick();

    // LCD abandons its request before ack; the pending CPU request follows.
    ack_lat = 10;
    tick();
    lcd_fml_stb = 1'b1;
    cpu_fml_stb = 1'b1;
    #1;
    tick();
    check("t5_gnt_stb", 32'(fml_stb), 32'd1);
    check("t5_gnt_adr", 32'(fml_adr), 32'(LcdAdr));
    tick();
    lcd_fml_stb = 1'b0;
    #1;
    check("t5_drop_stb", 32'(fml_stb), 32'd0);
    check("t5_drop_ack", 32'(lcd_fml_ack), 32'd0);
    tick();
    check("t5_idle_stb", 32'(fml_stb), 32'd0);
    check("t5_idle_do", 32'(fml_do), 32'd0);
    sb.push_back('{cpu: 1'b1, adr: CpuAdr});
    ack_lat = 1;
    tick();
    check("t5_cpu_stb", 32'(fml_stb), 32'd1);
    check("t5_cpu_adr", 32'(fml_adr), 32'(CpuAdr));
    check("t5_cpu_ack", 32'(cpu_fml_ack), 32'd1);
    tick();
    cpu_fml_stb = 1'b0;
    repeat (5) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fml_arb.md
VGA_FML_ARB -- requirements
Module: vga_fml_arb

Interface
REQ-001 SHALL have parameter fml_depth, default 20, width of all FML addresses (1MB video memory).
REQ-002 SHALL have parameter burst_len, default 4, number of 16-bit data beats per FML transaction, counted from the ack cycle inclusive.
REQ-003 SHALL have parameter lcd_max, default 4, maximum consecutive LCD grants while the CPU is requesting.
REQ-004 SHALL have port sys_clk, input, 1: single clock for all logic.
REQ-005 SHALL have port sys_rst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports lcd_fml_adr/stb/we/sel/do, inputs, fml_depth/1/1/2/16: LCD master request.
REQ-007 SHALL have port lcd_fml_ack, output, 1, and lcd_fml_di, output, 16: LCD master response.
REQ-008 SHALL have ports cpu_fml_adr/stb/we/sel/do, inputs, fml_depth/1/1/2/16: CPU master request.
REQ-009 SHALL have port cpu_fml_ack, output, 1, and cpu_fml_di, output, 16: CPU master response.
REQ-010 SHALL have ports fml_adr/stb/we/sel/do, outputs, fml_depth/1/1/2/16: merged request to the SDRAM controller.
REQ-011 SHALL have port fml_ack, input, 1, and fml_di, input, 16: SDRAM controller response.

Function
REQ-012 SHALL implement states IDLE, GNT_LCD, GNT_CPU and BURST, held in a registered state machine.
REQ-013 In IDLE with only lcd_fml_stb high, SHALL enter GNT_LCD on the next edge; with only cpu_fml_stb high, SHALL enter GNT_CPU.
REQ-014 In IDLE with both stb high, SHALL enter GNT_LCD unless lcd_run == lcd_max, in which case SHALL enter GNT_CPU.
REQ-015 lcd_run SHALL be a 3-bit counter that increments on each IDLE->GNT_LCD transition while cpu_fml_stb is high, saturating at lcd_max.
REQ-016 lcd_run SHALL clear on any IDLE->GNT_CPU transition and in any IDLE cycle where cpu_fml_stb is low.
REQ-017 In GNT_x, fml_stb SHALL equal the granted master's stb combinationally; fml_adr/we/sel SHALL be driven from the granted master.
REQ-018 In IDLE and BURST, fml_stb SHALL be 0.
REQ-019 fml_ack SHALL be routed to the granted master's ack output only; the other master's ack SHALL be 0.
REQ-020 In GNT_x with fml_ack high, SHALL enter BURST and load beat counter = burst_len-2; if burst_len == 1, SHALL go directly to IDLE.
REQ-021 In BURST, SHALL decrement the beat counter each cycle and return to IDLE on the cycle after it reaches 0; the grant owner SHALL be retained throughout.
REQ-022 fml_do SHALL be muxed from the grant owner in GNT_x and BURST, and SHALL be 0 in IDLE.
REQ-023 fml_di SHALL be broadcast unregistered to both lcd_fml_di and cpu_fml_di; each master qualifies the data with its own ack/burst timing.
REQ-024 Exactly one dead IDLE cycle SHALL separate consecutive transactions.
REQ-025 If the granted master drops stb in GNT_x before ack (illegal), SHALL return to IDLE on the next edge with no ack issued.
REQ-026 A request arriving from the non-granted master SHALL be held pending by that master and serviced only after return to IDLE.
REQ-027 Latency from master stb (IDLE) to fml_stb SHALL be exactly 1 cycle.

Reset
REQ-028 While sys_rst == 0 at a rising edge, SHALL force state IDLE, lcd_run = 0, beat counter = 0, grant owner = LCD.
REQ-029 During and after reset: fml_stb = 0, lcd_fml_ack = 0, cpu_fml_ack = 0, fml_do = 0.
REQ-030 Reset asserted mid-BURST SHALL abort the burst; fml_stb SHALL remain 0 until a new request is seen in IDLE.

Verification
REQ-031 LCD only, adr = 0x00100, ack at cycle 3 -> fml_stb high on cycles 1-3, lcd_fml_ack pulses once, BURST for cycles 4-6, IDLE at cycle 7.
REQ-032 Both stb high from reset release, lcd_max = 4 -> grant order L,L,L,L,C,L,L,L,L,C; cpu_fml_ack never asserted during LCD bursts.
REQ-033 CPU write, sel = 2'b01, do = 0xA55A -> fml_we = 1, fml_sel = 01, fml_do = 0xA55A through all 4 beats; lcd_fml_ack stays 0.
REQ-034 sys_rst = 0 asserted at the second BURST beat -> next cycle state IDLE, fml_stb = 0, lcd_run = 0; a CPU request after release is granted in 1 cycle.
REQ-035 LCD drops stb in GNT_LCD before ack -> IDLE next cycle, no ack, and a pending CPU request is granted on the following edge.
